seg_scan_ctrl: RTL and testbench

Upstream driver for the 4-digit seven-segment display stage (seg_disp). It generates the refresh-rate digit pointer and accepts 32-bit debug words (PC, ALU result) from the pipeline through a valid/ready handshake. It buffers each word and presents one 16-bit half (page) as count_val. Displayed data and page change only at frame boundaries, so digits never tear mid-scan.

---
 rtl/seg_scan_ctrl_pkg.sv | 23 ++
 rtl/seg_scan_ctrl_debounce.sv | 88 ++++++++
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller and its
// button debouncer.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } debState_e;

  localparam logic PAGE_LO = 1'b0;
  localparam logic PAGE_HI = 1'b1;

  localparam int DIGITS = 4;
  localparam int DIG_W  = $clog2(DIGITS);

  // The lower page shows data[15:0]; the upper page shows data[31:16].
  function automatic logic [15:0] selectPage(input logic [31:0] word, input logic page);
    return (page == PAGE_HI) ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_debounce.sv
// Page button conditioner. It synchronizes the raw button into the clock domain
// and emits one single-cycle press pulse for each stable press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  import seg_scan_ctrl_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic            meta_q;
  logic            btnS_q;
  debState_e       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      btnS_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      btnS_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // The counter is compared before it is incremented, so it never exceeds
  // CNT_MAX. The press pulse fires only on the PRESS_WAIT -> HELD transition,
  // which gives exactly one pulse per press, however long the button is held.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    press_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btnS_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btnS_q) begin
          state_d = IDLE;
        end else if (dcnt_q == CNT_MAX) begin
          state_d = HELD;
          press_o = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btnS_q) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btnS_q) begin
          state_d = HELD;
        end else if (dcnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller that feeds seg_disp. It buffers 32-bit debug words and
// presents one 16-bit page, updating data and page only at frame boundaries.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        page_btn,
  input  logic        freeze,
  output logic [15:0] count_val,
  output logic [1:0]  dig_pointer,
  output logic        page_sel,
  output logic        frame_start
);
  import seg_scan_ctrl_pkg::*;

  localparam int PRE_W = $clog2(REFRESH_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic [DIG_W-1:0] DIG_ONE  = DIG_W'(1);

  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic [DIG_W-1:0] digPointer_q, digPointer_d;
  logic             frameStart_q, frameStart_d;
  logic [31:0]      pending_q, pending_d;
  logic             pendingFull_q, pendingFull_d;
  logic [31:0]      shown_q, shown_d;
  logic             pageReq_q, pageReq_d;
  logic             pageSel_q, pageSel_d;

  logic tick;
  logic boundary;
  logic accept;
  logic transfer;
  logic pressPulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (page_btn),
    .press_o(pressPulse)
  );

  assign tick     = (prescaler_q == PRE_LAST);
  assign boundary = tick && (digPointer_q == DIG_LAST);
  assign accept   = data_valid && !pendingFull_q;
  assign transfer = boundary && pendingFull_q && !freeze;

  // Accept and transfer are mutually exclusive because accept needs an empty
  // pending slot. A word accepted on a boundary therefore waits a full frame.
  always_comb begin
    prescaler_d   = prescaler_q;
    digPointer_d  = digPointer_q;
    frameStart_d  = boundary;
    pending_d     = pending_q;
    pendingFull_d = pendingFull_q;
    shown_d       = shown_q;
    pageReq_d     = pageReq_q;
    pageSel_d     = pageSel_q;

    if (tick) begin
      prescaler_d  = '0;
      digPointer_d = (digPointer_q == DIG_LAST) ? '0 : digPointer_q + DIG_ONE;
    end else begin
      prescaler_d  = prescaler_q + PRE_ONE;
    end

    if (transfer) begin
      shown_d       = pending_q;
      pendingFull_d = 1'b0;
    end else if (accept) begin
      pending_d     = data_in;
      pendingFull_d = 1'b1;
    end

    if (boundary && !freeze) begin
      pageSel_d = pageReq_q;
    end

    if (pressPulse) begin
      pageReq_d = !pageReq_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_q   <= '0;
      digPointer_q  <= '0;
      frameStart_q  <= 1'b0;
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
      shown_q       <= '0;
      pageReq_q     <= PAGE_LO;
      pageSel_q     <= PAGE_LO;
    end else begin
      prescaler_q   <= prescaler_d;
      digPointer_q  <= digPointer_d;
      frameStart_q  <= frameStart_d;
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
      shown_q       <= shown_d;
      pageReq_q     <= pageReq_d;
      pageSel_q     <= pageSel_d;
    end
  end

  assign data_ready  = !pendingFull_q;
  assign dig_pointer = digPointer_q;
  assign frame_start = frameStart_q;
  assign page_sel    = pageSel_q;
  assign count_val   = selectPage(shown_q, pageSel_q);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl. It checks the DUT against a behavioural
// frame/handshake/page model every cycle, and also uses directed literal checks.
module tb_seg_scan_ctrl;

  localparam int RDIV  = 4;
  localparam int DEB   = 3;
  localparam int FRAME = RDIV * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        page_btn = 1'b0;
  logic        freeze = 1'b0;
  logic        data_ready;
  logic [15:0] count_val;
  logic [1:0]  dig_pointer;
  logic        page_sel;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .REFRESH_DIV    (RDIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .page_btn   (page_btn),
    .freeze     (freeze),
    .count_val  (count_val),
    .dig_pointer(dig_pointer),
    .page_sel   (page_sel),
    .frame_start(frame_start)
  );

  // Behavioural model. Timing comes from the cycle count since reset release.
  // The button model counts run lengths of the synchronized level.
  int          cyc = 0;
  bit          mPendFull = 0;
  logic [31:0] mPend = '0;
  logic [31:0] mShown = '0;
  bit          mPageReq = 0;
  bit          mPageSel = 0;
  bit          mHeld = 0;
  int          mRun = 0;
  bit          mSync0 = 0;
  bit          mSync1 = 0;

  always @(posedge clk or negedge rst) begin : model
    bit boundary;
    if (!rst) begin
      cyc = 0; mPendFull = 0; mPend = '0; mShown = '0;
      mPageReq = 0; mPageSel = 0; mHeld = 0; mRun = 0; mSync0 = 0; mSync1 = 0;
    end else begin
      boundary = (cyc % FRAME) == FRAME - 1;
      if (boundary && mPendFull && !freeze) begin
        mShown = mPend;
        mPendFull = 0;
      end else if (data_valid && !mPendFull) begin
        mPend = data_in;
        mPendFull = 1;
      end
      if (boundary && !freeze) mPageSel = mPageReq;
      if (mSync1 != mHeld) mRun++;
      else mRun = 0;
      if (mRun == DEB + 1) begin
        if (!mHeld) mPageReq = !mPageReq;
        mHeld = !mHeld;
        mRun = 0;
      end
      mSync1 = mSync0;
      mSync0 = page_btn;
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("dig_pointer", 32'(dig_pointer), 32'((cyc / RDIV) % 4));
    checkOutput("frame_start", 32'(frame_start), 32'(cyc > 0 && (cyc % FRAME) == 0));
    checkOutput("data_ready", 32'(data_ready), 32'(!mPendFull));
    checkOutput("page_sel", 32'(page_sel), 32'(mPageSel));
    checkOutput("count_val", 32'(count_val), 32'(mPageSel ? mShown[31:16] : mShown[15:0]));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input logic [31:0] data, input int n);
    data_valid = valid;
    data_in    = data;
    step(n);
  endtask

  task automatic waitFrame();
    bit seen = 0;
    for (int k = 0; k < 3 * FRAME && !seen; k++) begin
      step(1);
      if (frame_start) seen = 1;
    end
    checkOutput("frame_seen", 32'(seen), 32'd1);
  endtask

  // One press with a single-cycle bounce at the start, then a clean release.
  task automatic pressButton();
    page_btn = 1'b1; step(1);
    page_btn = 1'b0; step(1);
    page_btn = 1'b1; step(10);
    page_btn = 1'b0; step(10);
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    a = 32'hAAAA_5555;
    b = 32'hBBBB_6666;

    #7;
    checkOutput("rst_count_val", 32'(count_val), 32'h0);
    checkOutput("rst_ready", 32'(data_ready), 32'h1);
    checkOutput("rst_frame_start", 32'(frame_start), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Scan: frame period and alignment
    step(40);
    waitFrame();
    checkOutput("frame_dig0", 32'(dig_pointer), 32'h0);
    n = 0;
    do begin step(1); n++; end while (!frame_start && n < 40);
    checkOutput("frame_period", 32'(n), 32'd16);
    checkOutput("scan_count_val", 32'(count_val), 32'h0);

    // Handshake
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1);
    applyStimulus(1'b0, 32'h0, 0);
    checkOutput("hs_ready_low", 32'(data_ready), 32'h0);
    waitFrame();
    checkOutput("hs_count_val", 32'(count_val), 32'h0000_BEEF);
    checkOutput("hs_page", 32'(page_sel), 32'h0);
    checkOutput("hs_ready_back", 32'(data_ready), 32'h1);

    // Backpressure: A captured, B waits for the next free slot
    applyStimulus(1'b1, a, 1);
    applyStimulus(1'b1, b, 0);
    waitFrame();
    checkOutput("bp_first", 32'(count_val), 32'h0000_5555);
    step(2);
    applyStimulus(1'b0, 32'h0, 0);
    waitFrame();
    checkOutput("bp_second", 32'(count_val), 32'h0000_6666);

    // Page toggle
    pressButton();
    waitFrame();
    checkOutput("pg_sel", 32'(page_sel), 32'h1);
    checkOutput("pg_count_val", 32'(count_val), 32'h0000_BBBB);

    // Freeze: two presses return page_req to 1
    freeze = 1'b1;
    applyStimulus(1'b1, 32'h1234_5678, 1);
    applyStimulus(1'b0, 32'h0, 0);
    pressButton();
    pressButton();
    for (int f = 0; f < 3; f++) begin
      waitFrame();
      checkOutput("frz_count_val", 32'(count_val), 32'h0000_BBBB);
      checkOutput("frz_page", 32'(page_sel), 32'h1);
      checkOutput("frz_ready", 32'(data_ready), 32'h0);
    end
    freeze = 1'b0;
    waitFrame();
    checkOutput("unfrz_count_val", 32'(count_val), 32'h0000_1234);
    checkOutput("unfrz_page", 32'(page_sel), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(49) == 0) freeze = ~freeze;
      if ($urandom_range(7) == 0) page_btn = ~page_btn;
      applyStimulus($urandom_range(2) == 0, $urandom, 1);
    end

    // Reset mid-operation: pending full, page 1, debouncer in PRESS_WAIT
    freeze = 1'b0; page_btn = 1'b0;
    applyStimulus(1'b0, 32'h0, 40);
    if (!mPageSel) begin
      pressButton();
      waitFrame();
    end
    freeze = 1'b1;
    applyStimulus(1'b1, $urandom, 1);
    applyStimulus(1'b0, 32'h0, 0);
    page_btn = 1'b1;
    step(3);
    checkOutput("pre_rst_ready", 32'(data_ready), 32'h0);
    checkOutput("pre_rst_page", 32'(page_sel), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_count_val", 32'(count_val), 32'h0);
    checkOutput("mid_rst_page", 32'(page_sel), 32'h0);
    checkOutput("mid_rst_ready", 32'(data_ready), 32'h1);
    checkOutput("mid_rst_dig", 32'(dig_pointer), 32'h0);
    checkOutput("mid_rst_frame", 32'(frame_start), 32'h0);
    page_btn = 1'b0; freeze = 1'b0;
    step(2);
    rst = 1'b1;
    waitFrame();
    checkOutput("post_rst_count_val", 32'(count_val), 32'h0);
    checkOutput("post_rst_ready", 32'(data_ready), 32'h1);
    checkOutput("post_rst_page", 32'(page_sel), 32'h0);
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
